// File: rtl/log_scheduler.sv
// Round-robin scheduler sharing one pipelined log unit between N_REQ requesters,
// with a credit-protected result FIFO. Optional macro: LOG_RANGE_CHECK_EN.
module log_scheduler #(
    parameter int          N_REQ       = 4,
    parameter int          LOG_LATENCY = 2,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] ONE_FX      = 16'h0400
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [16*N_REQ-1:0]        req_data,
    output logic [15:0]                log_in,
    input  logic [15:0]                log_out,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [15:0]                rsp_data,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam int DATA_W = 16;
    localparam int ID_W   = $clog2(N_REQ);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH + LOG_LATENCY + 2) + 1;
    localparam logic [DATA_W-1:0] ERR_DATA = 16'h8000;

    function automatic logic [DATA_W-1:0] to_log_arg(input logic [DATA_W-1:0] x);
        return x - ONE_FX;
    endfunction

`ifdef LOG_RANGE_CHECK_EN
    // Taylor series only converges for 0 < x <= 2.0
    function automatic logic out_of_range(input logic [DATA_W-1:0] x);
        logic [DATA_W:0] lim;
        lim = {ONE_FX, 1'b0};
        return (x == '0) || ({1'b0, x} > lim);
    endfunction
`endif

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_any;
    logic [ID_W:0]     cand;
    logic [DATA_W-1:0] gnt_data;
    logic              credit_ok;
    logic              hs;
    logic [CW-1:0]     inflight_cnt;
    logic [AW:0]       fifo_cnt;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] cap_data;

    logic              vld_p [0:LOG_LATENCY];
    logic [ID_W-1:0]   id_p  [0:LOG_LATENCY];
    logic [ID_W-1:0]   mem_id   [0:FIFO_DEPTH-1];
    logic [DATA_W-1:0] mem_data [0:FIFO_DEPTH-1];
`ifdef LOG_RANGE_CHECK_EN
    logic              err_p [0:LOG_LATENCY];
    logic              mem_err  [0:FIFO_DEPTH-1];
`endif

    // Arbitration: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(N_REQ))
                cand = cand - (ID_W+1)'(N_REQ);
            if (!gnt_any && req_valid[cand[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_data = req_data[int'(gnt_id)*DATA_W +: DATA_W];
    end

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i <= LOG_LATENCY; i++)
            inflight_cnt = inflight_cnt + CW'(vld_p[i]);
    end

    // Counts are registered, so a pop only frees credit on the following cycle
    assign credit_ok = (CW'(fifo_cnt) + inflight_cnt) < CW'(FIFO_DEPTH);
    assign hs        = !RST && gnt_any && credit_ok;
    assign req_ready = hs ? (N_REQ'(1) << gnt_id) : '0;
    assign log_in    = (!RST && gnt_any) ? to_log_arg(gnt_data) : '0;

    // Stage p0 is loaded at the issue edge; stage pLOG_LATENCY lines up with log_out
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i <= LOG_LATENCY; i++)
                vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= hs;
            for (int i = 1; i <= LOG_LATENCY; i++)
                vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        id_p[0] <= gnt_id;
        for (int i = 1; i <= LOG_LATENCY; i++)
            id_p[i] <= id_p[i-1];
`ifdef LOG_RANGE_CHECK_EN
        err_p[0] <= out_of_range(gnt_data);
        for (int i = 1; i <= LOG_LATENCY; i++)
            err_p[i] <= err_p[i-1];
`endif
    end

    // Capture into the result FIFO
    assign push = vld_p[LOG_LATENCY];
    assign pop  = rsp_valid && rsp_ready;

`ifdef LOG_RANGE_CHECK_EN
    assign cap_data = err_p[LOG_LATENCY] ? ERR_DATA : log_out;
`else
    assign cap_data = log_out;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (hs)
                rr_ptr <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_id[wr_ptr]   <= id_p[LOG_LATENCY];
            mem_data[wr_ptr] <= cap_data;
`ifdef LOG_RANGE_CHECK_EN
            mem_err[wr_ptr]  <= err_p[LOG_LATENCY];
`endif
        end
    end

    // Head outputs are forced to zero when empty so stale entries never show
    assign rsp_valid = (fifo_cnt != '0);
    assign rsp_id    = rsp_valid ? mem_id[rd_ptr]   : '0;
    assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;
`ifdef LOG_RANGE_CHECK_EN
    assign rsp_err   = rsp_valid && mem_err[rd_ptr];
`else
    assign rsp_err   = 1'b0;
`endif
    assign busy      = (inflight_cnt != '0) || rsp_valid;

endmodule

// File: tb/tb_log_scheduler.sv
// Scoreboard bench for log_scheduler with a behavioural 3-term Taylor log unit.
module tb_log_scheduler;

    localparam int          N_REQ       = 4;
    localparam int          LOG_LATENCY = 2;
    localparam int          FIFO_DEPTH  = 4;
    localparam logic [15:0] ONE_FX      = 16'h0400;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [16*N_REQ-1:0]  req_data;
    logic [15:0]          log_in;
    logic [15:0]          log_out;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic [15:0]          rsp_data;
    logic                 rsp_err;
    logic                 busy;

    always #5 CLK = ~CLK;

    log_scheduler #(
        .N_REQ(N_REQ), .LOG_LATENCY(LOG_LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .ONE_FX(ONE_FX)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .log_in(log_in), .log_out(log_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    // Behavioural log unit: ln(1+v) ~ v - v^2/2 + v^3/3 in 5.10
    function automatic logic [15:0] lu_f(input logic [15:0] v);
        longint s, t2, t3;
        s  = longint'($signed(v));
        t2 = (s * s) >>> 11;
        t3 = ((s * s * s) >>> 20) / 3;
        return 16'(s - t2 + t3);
    endfunction

    logic [15:0] lu_pipe [0:LOG_LATENCY];
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i <= LOG_LATENCY; i++) lu_pipe[i] <= '0;
        end else begin
            lu_pipe[0] <= lu_f(log_in);
            for (int i = 1; i <= LOG_LATENCY; i++) lu_pipe[i] <= lu_pipe[i-1];
        end
    end
    assign log_out = lu_pipe[LOG_LATENCY];

    typedef struct packed {
        logic [1:0]  id;
        logic        err;
        logic [15:0] data;
    } rsp_t;

    rsp_t sbq[$];
    int   grants[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   hs_total = 0;
    int   pop_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rsp_t expect_rsp(input int id, input logic [15:0] x);
        rsp_t        e;
        logic [15:0] v;
        v     = x - ONE_FX;
        e.id  = 2'(id);
`ifdef LOG_RANGE_CHECK_EN
        e.err = (x == 16'h0000) || (x > 16'h0800);
`else
        e.err = 1'b0;
`endif
        e.data = e.err ? 16'h8000 : lu_f(v);
        return e;
    endfunction

    // Monitor: records issues into the scoreboard, checks every response popped
    always @(negedge CLK) begin
        if (RST) begin
            sbq.delete();
            hs_total  = 0;
            pop_total = 0;
        end else begin
            if (req_ready != '0) begin
                check("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
                for (int i = 0; i < N_REQ; i++) begin
                    if (req_ready[i]) begin
                        logic [15:0] x, exp_in;
                        x      = req_data[i*16 +: 16];
                        exp_in = x - ONE_FX;
                        check("ready_without_valid", 32'(req_valid[i]), 32'd1);
                        check("log_in", 32'(log_in), 32'(exp_in));
                        sbq.push_back(expect_rsp(i, x));
                        grants.push_back(i);
                        hs_total++;
                        check("no_overflow", 32'((hs_total - pop_total) <= FIFO_DEPTH), 32'd1);
                    end
                end
            end
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    rsp_t e;
                    e = sbq.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                end
                pop_total++;
            end
        end
    end

    task automatic set_req(input int i, input logic [15:0] x);
        req_data[i*16 +: 16] = x;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        rsp_ready = 1'b1;
        req_valid = '0;
        while ((sbq.size() != 0 || busy) && n < 100) begin
            tick();
            n++;
        end
        check({name, "_drain_pending"}, 32'(sbq.size()), 32'd0);
        check({name, "_drain_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req_ready"}, 32'(req_ready), 32'd0);
        check({name, "_log_in"},    32'(log_in),    32'd0);
        check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, "_rsp_id"},    32'(rsp_id),    32'd0);
        check({name, "_rsp_data"},  32'(rsp_data),  32'd0);
        check({name, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({name, "_busy"},      32'(busy),      32'd0);
    endtask

    // Single operand from requester i; waits (bounded) for its response at the head
    task automatic one_op(input string name, input int i, input logic [15:0] x,
                          input logic exp_err, input logic [15:0] exp_data);
        int n;
        rsp_ready = 1'b1;
        set_req(i, x);
        req_valid = N_REQ'(1) << i;
        tick();
        req_valid = '0;
        n = 0;
        @(negedge CLK);
        while (!rsp_valid && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
        check({name, "_err"},      32'(rsp_err),   32'(exp_err));
        check({name, "_data"},     32'(rsp_data),  32'(exp_data));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int exp_order [8];
        RST       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Reset values, even with a requester asserting valid
        req_valid = 4'b0001;
        set_req(0, 16'h0500);
        @(negedge CLK);
        check_reset_outputs("reset");
        tick();
        req_valid = '0;
        RST = 1'b0;
        @(negedge CLK);
        check("post_reset_busy", 32'(busy), 32'd0);
        tick();

        // Fairness: all requesters valid, grants rotate from rr_ptr=0
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        grants.delete();
        set_req(0, 16'h0480);
        set_req(1, 16'h0500);
        set_req(2, 16'h0600);
        set_req(3, 16'h0700);
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        repeat (14) tick();
        req_valid = '0;
        check("fair_grant_count", 32'(grants.size() >= 8), 32'd1);
        for (int k = 0; k < 8; k++)
            if (k < grants.size())
                check("fair_grant_order", 32'(grants[k]), 32'(exp_order[k]));
        drain("fair");

        // Single op: requester 2, x=1.5, result lands 3 edges after issue
        rsp_ready = 1'b1;
        set_req(2, 16'h0600);
        req_valid = 4'b0100;
        @(negedge CLK);
        check("single_req_ready", 32'(req_ready), 32'h4);
        check("single_log_in", 32'(log_in), 32'h0200);
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("single_latency", 32'(rsp_valid), (k == 3) ? 32'd1 : 32'd0);
        end
        check("single_rsp_id", 32'(rsp_id), 32'd2);
        check("single_rsp_data", 32'(rsp_data), 32'h01AA);
        check("single_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        drain("single");

        // Push and pop on the same edge: count holds, second result becomes head
        rsp_ready = 1'b0;
        set_req(1, 16'h0800);
        req_valid = 4'b0010;
        tick();
        set_req(1, 16'h0300);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("simul_head_valid", 32'(rsp_valid), 32'd1);
        check("simul_head_data", 32'(rsp_data), 32'h0355);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        @(negedge CLK);
        check("simul_still_valid", 32'(rsp_valid), 32'd1);
        check("simul_next_id", 32'(rsp_id), 32'd1);
        check("simul_next_data", 32'(rsp_data), 32'hFEDB);
        check("simul_busy", 32'(busy), 32'd1);
        tick();
        drain("simul");

        // Backpressure: exactly FIFO_DEPTH issues, then one per freed slot
        rsp_ready = 1'b0;
        base = hs_total;
        req_valid = 4'hF;
        repeat (10) tick();
        check("bp_handshakes", 32'(hs_total - base), 32'd4);
        @(negedge CLK);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        base = hs_total;
        repeat (6) tick();
        check("bp_one_more", 32'(hs_total - base), 32'd1);
        drain("bp");

        // Range boundaries
`ifdef LOG_RANGE_CHECK_EN
        one_op("range_zero", 0, 16'h0000, 1'b1, 16'h8000);
        one_op("range_high", 3, 16'h0C00, 1'b1, 16'h8000);
        one_op("range_one",  1, 16'h0400, 1'b0, 16'h0000);
`else
        one_op("range_zero", 0, 16'h0000, 1'b0, 16'hF8AB);
        one_op("range_high", 3, 16'h0C00, 1'b0, 16'h0AAA);
        one_op("range_one",  1, 16'h0400, 1'b0, 16'h0000);
`endif
        drain("range");

        // Reset with 2 ops in flight and 1 in the FIFO
        rsp_ready = 1'b0;
        set_req(0, 16'h0500);
        req_valid = 4'b0001;
        tick();
        set_req(0, 16'h0600);
        tick();
        set_req(0, 16'h0700);
        tick();
        req_valid = '0;
        tick();
        check("mid_fifo_valid", 32'(rsp_valid), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_outputs("mid_reset");
        tick();
        RST = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check("mid_no_stale", 32'(rsp_valid), 32'd0);
        end
        check("mid_busy_after", 32'(busy), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
